// File: rtl/fxp_mult_pipe.sv
// Pipelined signed fixed-point multiply / multiply-accumulate with round-half-up and overflow flag.
// Optional saturation on overflow when FXP_MULT_SAT_EN is defined; otherwise results wrap.
module fxp_mult_pipe #(
    parameter int W = 16,
    parameter int F = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_acc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf
);

    localparam int L  = $clog2(W);
    localparam int P  = 1 << L;
    localparam int PW = 2 * W;
    localparam int SW = 2 * W + 1;
    localparam logic [PW-1:0] HALF = PW'(1) << (F - 1);

    logic          advance;
    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic          out_ovf_q;
    logic [W-1:0]  acc_q;
    logic [L:0]    vld_q;
    logic [L:0]    accf_q;
    logic [PW-1:0] a_ext;
    logic [PW-1:0] pp_d [P];

    // One stall signal freezes every stage, valid bits included, so beats never slip.
    assign advance   = out_ready | ~out_valid_q;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    assign a_ext = {{W{in_a[W-1]}}, in_a};

    // The multiplier's sign bit carries weight -2^(W-1), so its row is subtracted.
    for (genvar i = 0; i < W; i++) begin : g_pp
        if (i < W - 1) begin : g_pos
            assign pp_d[i] = in_b[i] ? (a_ext << i) : '0;
        end else begin : g_neg
            assign pp_d[i] = in_b[i] ? ('0 - (a_ext << i)) : '0;
        end
    end

    for (genvar i = W; i < P; i++) begin : g_pad
        assign pp_d[i] = '0;
    end

    for (genvar lv = 0; lv <= L; lv++) begin : g_lvl
        localparam int N = P >> lv;
        logic [PW-1:0] sum_q [N];

        if (lv == 0) begin : g_leaf
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sum_q <= '{default: '0};
                end else if (advance) begin
                    sum_q <= pp_d;
                end
            end
        end else begin : g_node
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sum_q <= '{default: '0};
                end else if (advance) begin
                    for (int j = 0; j < N; j++) begin
                        sum_q[j] <= g_lvl[lv-1].sum_q[2*j] + g_lvl[lv-1].sum_q[2*j+1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q  <= '0;
            accf_q <= '0;
        end else if (advance) begin
            vld_q  <= {vld_q[L-1:0], in_valid};
            accf_q <= {accf_q[L-1:0], in_acc};
        end
    end

    logic [PW-1:0]        prod;
    logic [PW-1:0]        rnd_sum;
    logic signed [PW-1:0] rnd;
    logic signed [SW-1:0] acc_ext;
    logic signed [SW-1:0] res_full;
    logic                 res_ovf;
    logic [W-1:0]         res_d;

    // Accumulator is read here, in the last stage, so a chained beat always sees its predecessor.
    always_comb begin
        prod     = g_lvl[L].sum_q[0];
        rnd_sum  = prod + HALF;
        rnd      = $signed(rnd_sum) >>> F;
        acc_ext  = accf_q[L] ? $signed({{(SW-W){acc_q[W-1]}}, acc_q}) : '0;
        res_full = $signed({rnd[PW-1], rnd}) + acc_ext;
        res_ovf  = ~((&res_full[SW-1:W-1]) | ~(|res_full[SW-1:W-1]));
`ifdef FXP_MULT_SAT_EN
        if (res_ovf) begin
            res_d = res_full[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            res_d = res_full[W-1:0];
        end
`else
        res_d = res_full[W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            acc_q       <= '0;
        end else if (advance) begin
            out_valid_q <= vld_q[L];
            if (vld_q[L]) begin
                out_data_q <= res_d;
                out_ovf_q  <= res_ovf;
                acc_q      <= res_d;
            end
        end
    end

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Directed self-checking bench for fxp_mult_pipe (W=16, F=8) with a scoreboard of hand-computed results.
module tb_fxp_mult_pipe;

    localparam int W = 16;
    localparam int F = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_acc = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_ovf;

    typedef struct {
        logic [W-1:0] data;
        logic         ovf;
        int           acceptEdge;
        bit           checkLat;
    } exp_t;

    exp_t expQ[$];
    int   totalChecks = 0;
    int   badChecks = 0;
    int   edgeNo = 0;
    int   consumed = 0;

    fxp_mult_pipe #(.W(W), .F(F)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_acc    (in_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    // One cycle: drive at the falling edge, look at outputs 1ns later, before the next rising edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic acc, input logic ordy, output logic accepted);
        exp_t e;
        @(negedge clk);
        edgeNo++;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_acc    = acc;
        out_ready = ordy;
        #1;
        accepted = in_valid && in_ready;
        if (out_valid && !out_ready) checkOutput("stall_in_ready", in_ready, 0);
        if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_out", out_valid, 0);
            end else begin
                e = expQ.pop_front();
                consumed++;
                checkOutput("out_data", out_data, e.data);
                checkOutput("out_ovf", out_ovf, e.ovf);
                if (e.checkLat) checkOutput("latency", edgeNo - e.acceptEdge, 6);
            end
        end
    endtask

    task automatic sendBeat(input logic [W-1:0] a, input logic [W-1:0] b, input logic acc,
                            input logic [W-1:0] expData, input logic expOvf);
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) applyStimulus(1'b1, a, b, acc, 1'b1, ok);
        checkOutput("send_accept", ok, 1);
        if (ok) expQ.push_back('{expData, expOvf, edgeNo, 1'b1});
    endtask

    task automatic drain();
        logic dummy;
        for (int t = 0; t < 60 && expQ.size() != 0; t++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, dummy);
        checkOutput("drain_empty", expQ.size(), 0);
    endtask

    initial begin
        logic         accd;
        logic         v;
        logic         ordy;
        int           bi;
        int           startEdge;
        int           consumed0;
        logic [W-1:0] ovfData;

        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_out_ovf", out_ovf, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;

        // Basic products and rounding
        sendBeat(16'h0180, 16'h0200, 1'b0, 16'h0300, 1'b0);
        drain();
        sendBeat(16'hFE80, 16'h0200, 1'b0, 16'hFD00, 1'b0);
        sendBeat(16'h0001, 16'h0080, 1'b0, 16'h0001, 1'b0);
        sendBeat(16'h0001, 16'h007F, 1'b0, 16'h0000, 1'b0);
        sendBeat(16'hFF00, 16'hFF00, 1'b0, 16'h0100, 1'b0);
        drain();

`ifdef FXP_MULT_SAT_EN
        ovfData = 16'h7FFF;
`else
        ovfData = 16'hFE00;
`endif
        sendBeat(16'h7F00, 16'h0200, 1'b0, ovfData, 1'b1);
        drain();

        // Back-to-back accumulate chain, also checks one beat per cycle
        startEdge = edgeNo;
        sendBeat(16'h0100, 16'h0100, 1'b0, 16'h0100, 1'b0);
        sendBeat(16'h0100, 16'h0100, 1'b1, 16'h0200, 1'b0);
        sendBeat(16'h0100, 16'h0100, 1'b1, 16'h0300, 1'b0);
        sendBeat(16'h0100, 16'h0100, 1'b1, 16'h0400, 1'b0);
        checkOutput("throughput", edgeNo - startEdge, 4);
        drain();

        // Stream of 12 beats with a 10-cycle output stall in the middle
        bi = 0;
        consumed0 = consumed;
        for (int c = 0; c < 200 && (consumed - consumed0) < 12; c++) begin
            v    = (bi < 12);
            ordy = !(c >= 8 && c < 18);
            applyStimulus(v, 16'((bi + 1) * 256), 16'h0180, 1'b0, ordy, accd);
            if (accd) begin
                expQ.push_back('{16'((bi + 1) * 384), 1'b0, edgeNo, 1'b0});
                bi++;
            end
        end
        checkOutput("stall_count", consumed - consumed0, 12);
        checkOutput("stall_queue", expQ.size(), 0);

        // Reset with beats in flight; accumulator must restart from zero
        for (int k = 1; k <= 6; k++) sendBeat(16'(k * 256), 16'h0100, 1'b0, 16'(k * 256), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("pre_reset_valid", out_valid, 1);
        reset = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_data", out_data, 0);
        checkOutput("midrst_out_ovf", out_ovf, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        expQ.delete();
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_a      = 16'h0100;
        in_b      = 16'h0100;
        in_acc    = 1'b1;
        out_ready = 1'b1;
        edgeNo++;
        #1;
        checkOutput("release_in_ready", in_ready, 1);
        expQ.push_back('{16'h0100, 1'b0, edgeNo, 1'b1});
        drain();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
